wrapped_adder_measure_seq: RTL and testbench

WRAPPED_ADDER_MEASURE_SEQ -- requirements
Module: wrapped_adder_measure_seq

---
 rtl/adder_measure_pkg.sv | 15 +
 rtl/measure_stats.sv | 46 ++++
 rtl/wrapped_adder_measure_seq.sv | 124 ++++++++++++
 tb/tb_wrapped_adder_measure_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/adder_measure_pkg.sv
// Shared types and defaults for the adder ring-oscillator measurement sequencer.
// Optional averaging output is enabled with MEASURE_SEQ_AVG_EN.
package adder_measure_pkg;
    localparam int CNT_W_DEF = 32;
    localparam int WIN_W_DEF = 16;
    localparam int EXP_MAX   = 4;

    typedef enum logic [2:0] {
        IDLE, CLEAR, RUN, SETTLE, CAPTURE, DONE
    } state_t;

    function automatic logic [2:0] clamp_exp(input logic [2:0] e);
        return (e > 3'(EXP_MAX)) ? 3'(EXP_MAX) : e;
    endfunction
endpackage

// File: rtl/measure_stats.sv
// Min/max (and optional sum, MEASURE_SEQ_AVG_EN) tracker over a series of ring counts.
module measure_stats
    import adder_measure_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             update,
    input  logic [CNT_W-1:0] sample,
    output logic [CNT_W-1:0] min_val,
    output logic [CNT_W-1:0] max_val
`ifdef MEASURE_SEQ_AVG_EN
    ,
    output logic [CNT_W+3:0] sum
`endif
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_val <= '0;
            max_val <= '0;
        end else if (clr) begin
            min_val <= '0;
            max_val <= '0;
        end else if (load) begin
            min_val <= sample;
            max_val <= sample;
        end else if (update) begin
            if (sample < min_val) min_val <= sample;
            if (sample > max_val) max_val <= sample;
        end
    end

`ifdef MEASURE_SEQ_AVG_EN
    // Four guard bits cover the worst case of 16 full-scale samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 sum <= '0;
        else if (clr)            sum <= '0;
        else if (load || update) sum <= sum + (CNT_W+4)'(sample);
    end
`endif

endmodule

// File: rtl/wrapped_adder_measure_seq.sv
// Sequencer that runs an instrumented adder ring 2^exp times and reports count min/max.
// Define MEASURE_SEQ_AVG_EN to add the res_avg output.
module wrapped_adder_measure_seq
    import adder_measure_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [WIN_W-1:0] cmd_window,
    input  logic [2:0]       cmd_exp,
    output logic [31:0]      adder_a,
    output logic [31:0]      adder_b,
    output logic             adder_run,
    output logic             adder_cnt_clr,
    input  logic [CNT_W-1:0] adder_count,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_min,
    output logic [CNT_W-1:0] res_max,
    output logic             busy
`ifdef MEASURE_SEQ_AVG_EN
    ,
    output logic [CNT_W-1:0] res_avg
`endif
);

    state_t             state, state_nxt;
    logic [31:0]        a_r, b_r;
    logic [WIN_W-1:0]   win_r, run_cnt;
    logic [2:0]         exp_r;
    logic [4:0]         rem;
    logic               first;
    logic               accept;

    assign accept = cmd_valid && (state == IDLE);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = CLEAR;
            CLEAR:   state_nxt = RUN;
            RUN:     if (run_cnt == '0) state_nxt = SETTLE;
            SETTLE:  state_nxt = CAPTURE;
            CAPTURE: state_nxt = (rem == 5'd1) ? DONE : CLEAR;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded straight from the state register so reset drops adder_run asynchronously.
    assign cmd_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign adder_cnt_clr = (state == CLEAR);
    assign adder_run     = (state == RUN);
    assign res_valid     = (state == DONE);
    assign adder_a       = a_r;
    assign adder_b       = b_r;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            a_r     <= '0;
            b_r     <= '0;
            win_r   <= '0;
            exp_r   <= '0;
            rem     <= '0;
            run_cnt <= '0;
            first   <= 1'b0;
        end else begin
            if (accept) begin
                a_r   <= cmd_a;
                b_r   <= cmd_b;
                win_r <= cmd_window;
                exp_r <= clamp_exp(cmd_exp);
                rem   <= 5'd1 << clamp_exp(cmd_exp);
                first <= 1'b1;
            end
            // run_cnt counts down to zero; a zero window still gets one RUN cycle.
            if (state == CLEAR)
                run_cnt <= (win_r == '0) ? '0 : win_r - 1'b1;
            else if (state == RUN && run_cnt != '0)
                run_cnt <= run_cnt - 1'b1;
            if (state == CAPTURE) begin
                rem   <= rem - 5'd1;
                first <= 1'b0;
            end
        end
    end

`ifdef MEASURE_SEQ_AVG_EN
    logic [CNT_W+3:0] sum, sum_shift;
`endif

    measure_stats #(.CNT_W(CNT_W)) u_stats (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clr     (accept),
        .load    (state == CAPTURE && first),
        .update  (state == CAPTURE && !first),
        .sample  (adder_count),
        .min_val (res_min),
        .max_val (res_max)
`ifdef MEASURE_SEQ_AVG_EN
        ,
        .sum     (sum)
`endif
    );

`ifdef MEASURE_SEQ_AVG_EN
    assign sum_shift = sum >> exp_r;
    assign res_avg   = sum_shift[CNT_W-1:0];
`endif

endmodule

// File: tb/tb_wrapped_adder_measure_seq.sv
// Directed, table-driven bench for wrapped_adder_measure_seq (optionally with MEASURE_SEQ_AVG_EN).
// Latency is counted in rising edges with the accepting edge as edge 1.
module tb_wrapped_adder_measure_seq;

    logic        wb_clk_i, wb_rst_i;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_a, cmd_b;
    logic [15:0] cmd_window;
    logic [2:0]  cmd_exp;
    logic [31:0] adder_a, adder_b;
    logic        adder_run, adder_cnt_clr;
    logic [31:0] adder_count;
    logic        res_valid, res_ready;
    logic [31:0] res_min, res_max, res_avg;
    logic        busy;

    int total = 0;
    int bad   = 0;

    wrapped_adder_measure_seq dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .cmd_window    (cmd_window),
        .cmd_exp       (cmd_exp),
        .adder_a       (adder_a),
        .adder_b       (adder_b),
        .adder_run     (adder_run),
        .adder_cnt_clr (adder_cnt_clr),
        .adder_count   (adder_count),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_min       (res_min),
        .res_max       (res_max),
        .busy          (busy)
`ifdef MEASURE_SEQ_AVG_EN
        ,
        .res_avg       (res_avg)
`endif
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [31:0]       a, b;
        logic [15:0]       win;
        logic [2:0]        exp;
        logic [15:0][31:0] cnt;
        logic [31:0]       emin, emax, eavg;
        int                elat, eruns, eclr, stall;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc, k, runs, clrs;
        logic seen, stable;
        @(negedge wb_clk_i);
        cmd_a = v.a; cmd_b = v.b; cmd_window = v.win; cmd_exp = v.exp;
        cmd_valid = 1'b1;
        cyc = 0; k = 0; runs = 0; clrs = 0; seen = 1'b0;
        while (!seen && cyc < v.elat + 50) begin
            @(posedge wb_clk_i); #1;
            cyc++;
            cmd_valid = 1'b0;
            if (adder_cnt_clr) begin
                clrs++;
                if (k < 16) adder_count = v.cnt[k];
                k++;
            end
            if (adder_run) runs++;
            if (res_valid) seen = 1'b1;
        end
        chk("res_valid_seen", seen, 1);
        chk("latency", cyc, v.elat);
        chk("res_min", res_min, v.emin);
        chk("res_max", res_max, v.emax);
        chk("clear_pulses", clrs, v.eclr);
        chk("run_cycles", runs, v.eruns);
        chk("adder_a_hold", adder_a, v.a);
        chk("adder_b_hold", adder_b, v.b);
        chk("busy_done", busy, 1);
`ifdef MEASURE_SEQ_AVG_EN
        chk("res_avg", res_avg, v.eavg);
`endif
        // Hold off the result consumer; a command offered meanwhile must be dropped.
        for (int s = 0; s < v.stall; s++) begin
            @(posedge wb_clk_i); #1;
            stable = res_valid && res_min == v.emin && res_max == v.emax &&
                     adder_a == v.a && !adder_cnt_clr && !cmd_ready;
            chk("stall_stable", stable, 1);
            cmd_valid = (s == 3);
            cmd_a = ~v.a;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge wb_clk_i); #1;
        res_ready = 1'b0;
        chk("res_valid_drop", res_valid, 0);
        chk("idle_after_ack", {busy, cmd_ready}, 2'b01);
        @(posedge wb_clk_i); #1;
        chk("no_queued_cmd", {busy, adder_cnt_clr}, 2'b00);
    endtask

    initial begin
        logic flag;
        vecs[0] = '{a:32'd5, b:32'd7, win:16'd10, exp:3'd0, cnt:'0,
                    emin:32'd123, emax:32'd123, eavg:32'd123, elat:14, eruns:10, eclr:1, stall:20};
        vecs[0].cnt[0] = 32'd123;
        vecs[1] = '{a:32'h1234, b:32'hABCD, win:16'd3, exp:3'd2, cnt:'0,
                    emin:32'd31, emax:32'd60, eavg:32'd46, elat:25, eruns:12, eclr:4, stall:4};
        vecs[1].cnt[0] = 32'd40; vecs[1].cnt[1] = 32'd55;
        vecs[1].cnt[2] = 32'd31; vecs[1].cnt[3] = 32'd60;
        vecs[2] = '{a:32'd1, b:32'd2, win:16'd0, exp:3'd1, cnt:'0,
                    emin:32'd4, emax:32'd9, eavg:32'd6, elat:9, eruns:2, eclr:2, stall:4};
        vecs[2].cnt[0] = 32'd9; vecs[2].cnt[1] = 32'd4;
        // exp=7 clamps to 16 measurements; counts are 50..65 in scrambled order, sum 920.
        vecs[3] = '{a:32'hDEAD_BEEF, b:32'h0BAD_F00D, win:16'd2, exp:3'd7, cnt:'0,
                    emin:32'd50, emax:32'd65, eavg:32'd57, elat:81, eruns:32, eclr:16, stall:4};
        for (int i = 0; i < 16; i++) vecs[3].cnt[i] = 32'd50 + 32'((i * 7) % 16);
        vecs[4] = '{a:32'hFFFF_FFFF, b:32'd0, win:16'd1, exp:3'd1, cnt:'0,
                    emin:32'd0, emax:32'hFFFF_FFFF, eavg:32'h7FFF_FFFF, elat:9, eruns:2, eclr:2, stall:4};
        vecs[4].cnt[0] = 32'hFFFF_FFFF; vecs[4].cnt[1] = 32'd0;
        vecs[5] = '{a:32'd3, b:32'd4, win:16'd0, exp:3'd5, cnt:'0,
                    emin:32'd10, emax:32'd10, eavg:32'd10, elat:65, eruns:16, eclr:16, stall:4};
        for (int i = 0; i < 16; i++) vecs[5].cnt[i] = 32'd10;

        wb_rst_i = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_window = '0; cmd_exp = '0; adder_count = '0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        chk("rst_ctrl", {cmd_ready, busy, res_valid, adder_run, adder_cnt_clr}, 5'b10000);
        chk("rst_result", {res_min, res_max}, 64'd0);
        chk("rst_operand", {adder_a, adder_b}, 64'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset in the middle of RUN aborts the measurement.
        @(negedge wb_clk_i);
        cmd_a = 32'd99; cmd_b = 32'd1; cmd_window = 16'd20; cmd_exp = 3'd0;
        cmd_valid = 1'b1;
        @(posedge wb_clk_i); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge wb_clk_i);
        #1;
        chk("run_before_rst", adder_run, 1);
        #2 wb_rst_i = 1'b1;
        #1;
        chk("rst_async_run", adder_run, 0);
        chk("rst_async_idle", {cmd_ready, busy}, 2'b10);
        chk("rst_async_operand", adder_a, 0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        flag = 1'b0;
        repeat (40) begin
            @(posedge wb_clk_i); #1;
            if (res_valid || adder_run || busy) flag = 1'b1;
        end
        chk("abort_no_result", flag, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
